alu_exec_unit: RTL and testbench

- Parametrised successor to the combinational ALU control decode.
- Decodes alu_op/funct3/funct7 internally and executes the operation.
- Base ops take one cycle. RV32M multiply/divide ops run on an iterative multi-cycle datapath.
- Sits in the EX stage and drives a valid/ready handshake toward the pipeline control.

---
 rtl/alu_exec_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with built-in control decode.
// Base operations finish in one cycle. When ALU_EXEC_MD_EN is defined, the
// RV32M multiply/divide operations run on an iterative shift-add /
// restoring-divide datapath (IDLE -> ITER -> FIX -> IDLE).
module alu_exec_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [3:0]      alu_op_i,
   input  logic [2:0]      funct_3_i,
   input  logic [6:0]      funct_7_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   output logic [XLEN-1:0] result_o,
   output logic            branch_o,
   output logic            valid_o
);

   localparam int unsigned SH_W = CNT_W - 1;

   logic [XLEN-1:0] sum_c;
   logic [XLEN-1:0] alu_res_c;
   logic            br_c;
   logic            accept_c;

   assign sum_c = op_a_i + op_b_i;

   // Decode and evaluate all single-cycle operations
   always_comb begin
      alu_res_c = sum_c;
      br_c      = 1'b0;
      case (alu_op_i)
         4'b0000: begin
            if (funct_7_i == 7'b0000000 && funct_3_i == 3'b100)
               alu_res_c = op_a_i ^ op_b_i;
            else if (funct_7_i == 7'b0100000 && funct_3_i == 3'b000)
               alu_res_c = op_a_i - op_b_i;
         end
         4'b0001: alu_res_c = op_b_i;
         4'b0010: begin
            if (funct_3_i == 3'b101)
               br_c = ($signed(op_a_i) >= $signed(op_b_i));
            else if (funct_3_i == 3'b001)
               br_c = (op_a_i != op_b_i);
         end
         4'b0011: alu_res_c = op_a_i + XLEN'(4);
         4'b0101: begin
            case (funct_3_i)
               3'b001:  alu_res_c = op_a_i << op_b_i[SH_W-1:0];
               3'b101:  alu_res_c = $signed(op_a_i) >>> op_b_i[SH_W-1:0];
               default: alu_res_c = sum_c;
            endcase
         end
         default: alu_res_c = sum_c;
      endcase
   end

`ifdef ALU_EXEC_MD_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_q, state_d;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   opnd_q;
   logic              neg_a_q, neg_b_q;
   logic [2:0]        fn_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              md_c;
   logic              sgn_a_c, sgn_b_c, neg_a_c, neg_b_c;
   logic [XLEN-1:0]   mag_a_c, mag_b_c;
   logic              div_zero_c, div_ovf_c;
   logic [XLEN:0]     mul_sum_c, div_sh_c;
   logic [XLEN-1:0]   div_dif_c;
   logic              div_ge_c;
   logic [2*XLEN-1:0] step_c, prod_c;
   logic [XLEN-1:0]   fix_res_c;

   assign md_c     = (alu_op_i == 4'b0000) && (funct_7_i == 7'b0000001);
   assign ready_o  = (state_q == IDLE);
   assign accept_c = valid_i && ready_o && !flush_i;

   // Operand signedness, magnitudes and divide special cases at accept
   always_comb begin
      sgn_a_c    = (funct_3_i == 3'b001) || (funct_3_i == 3'b010) ||
                   (funct_3_i == 3'b100) || (funct_3_i == 3'b110);
      sgn_b_c    = (funct_3_i == 3'b001) || (funct_3_i == 3'b100) ||
                   (funct_3_i == 3'b110);
      neg_a_c    = sgn_a_c && op_a_i[XLEN-1];
      neg_b_c    = sgn_b_c && op_b_i[XLEN-1];
      mag_a_c    = neg_a_c ? -op_a_i : op_a_i;
      mag_b_c    = neg_b_c ? -op_b_i : op_b_i;
      div_zero_c = funct_3_i[2] && (op_b_i == '0);
      div_ovf_c  = funct_3_i[2] && !funct_3_i[0] &&
                   (op_a_i == MIN_VAL) && (op_b_i == '1);
   end

   // One multiply or divide iteration on the shared accumulator
   always_comb begin
      mul_sum_c = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
      div_sh_c  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_ge_c  = (div_sh_c >= {1'b0, opnd_q});
      div_dif_c = div_sh_c[XLEN-1:0] - opnd_q;
      if (fn_q[2])
         step_c = {(div_ge_c ? div_dif_c : div_sh_c[XLEN-1:0]),
                   acc_q[XLEN-2:0], div_ge_c};
      else
         step_c = {mul_sum_c, acc_q[XLEN-1:1]};
   end

   // Sign correction and result selection in FIX
   always_comb begin
      prod_c = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      if (!fn_q[2])
         fix_res_c = (fn_q == 3'b000) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
      else if (fn_q[1])
         fix_res_c = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      else
         fix_res_c = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_c && md_c)
               state_d = (div_zero_c || div_ovf_c) ? FIX : ITER;
         end
         ITER: begin
            if (flush_i)                     state_d = IDLE;
            else if (cnt_q == CNT_W'(1))     state_d = FIX;
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_o <= '0;
         branch_o <= 1'b0;
         valid_o  <= 1'b0;
         acc_q    <= '0;
         opnd_q   <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         fn_q     <= '0;
         cnt_q    <= '0;
      end else begin
         valid_o <= 1'b0;
         if (accept_c) begin
            branch_o <= br_c;
            if (!md_c) begin
               result_o <= alu_res_c;
               valid_o  <= 1'b1;
            end else begin
               fn_q  <= funct_3_i;
               cnt_q <= CNT_W'(XLEN);
               if (div_zero_c) begin
                  acc_q   <= {op_a_i, {XLEN{1'b1}}};
                  neg_a_q <= 1'b0;
                  neg_b_q <= 1'b0;
               end else if (div_ovf_c) begin
                  acc_q   <= {{XLEN{1'b0}}, MIN_VAL};
                  neg_a_q <= 1'b0;
                  neg_b_q <= 1'b0;
               end else if (funct_3_i[2]) begin
                  acc_q   <= {{XLEN{1'b0}}, mag_a_c};
                  opnd_q  <= mag_b_c;
                  neg_a_q <= neg_a_c;
                  neg_b_q <= neg_b_c;
               end else begin
                  acc_q   <= {{XLEN{1'b0}}, mag_b_c};
                  opnd_q  <= mag_a_c;
                  neg_a_q <= neg_a_c;
                  neg_b_q <= neg_b_c;
               end
            end
         end
         if (state_q == ITER) begin
            acc_q <= step_c;
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (state_q == FIX && !flush_i) begin
            result_o <= fix_res_c;
            valid_o  <= 1'b1;
         end
      end
   end
`else
   assign ready_o  = 1'b1;
   assign accept_c = valid_i && !flush_i;

   // Output registers: every accepted operation completes in one cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_o <= '0;
         branch_o <= 1'b0;
         valid_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (accept_c) begin
            result_o <= alu_res_c;
            branch_o <= br_c;
            valid_o  <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed cases plus randomized operations
// compared against a plain-arithmetic reference model. Follows the build
// setting of ALU_EXEC_MD_EN.
module tb_alu_exec_unit;

   localparam int unsigned XLEN = 32;
`ifdef ALU_EXEC_MD_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            flush_i;
   logic            valid_i;
   logic            ready_o;
   logic [3:0]      alu_op_i;
   logic [2:0]      funct_3_i;
   logic [6:0]      funct_7_i;
   logic [XLEN-1:0] op_a_i;
   logic [XLEN-1:0] op_b_i;
   logic [XLEN-1:0] result_o;
   logic            branch_o;
   logic            valid_o;

   int              n_checks = 0;
   int              n_fail   = 0;
   logic [31:0]     last_res = '0;

   alu_exec_unit #(.XLEN(XLEN)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .alu_op_i  (alu_op_i),
      .funct_3_i (funct_3_i),
      .funct_7_i (funct_7_i),
      .op_a_i    (op_a_i),
      .op_b_i    (op_b_i),
      .result_o  (result_o),
      .branch_o  (branch_o),
      .valid_o   (valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: result, branch flag and latency from the ISA rules
   function automatic void model(input logic [3:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] res,
                                 output logic br, output int lat);
      longint      sa, sb;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = a + b;
      br  = 1'b0;
      lat = 1;
      case (op)
         4'd0: begin
            if (f7 == 7'h00 && f3 == 3'd4)      res = a ^ b;
            else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
            else if (f7 == 7'h01 && MD_EN) begin
               lat = 34;
               case (f3)
                  3'd0: begin p = 64'(sa * sb); res = p[31:0];  end
                  3'd1: begin p = 64'(sa * sb); res = p[63:32]; end
                  3'd2: begin p = 64'(sa * longint'({32'b0, b})); res = p[63:32]; end
                  3'd3: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; end
                  3'd4: begin
                     if (b == 0)                            begin res = '1; lat = 2; end
                     else if (a == 32'h80000000 && b == '1) begin res = a;  lat = 2; end
                     else res = 32'(sa / sb);
                  end
                  3'd5: begin
                     if (b == 0) begin res = '1; lat = 2; end
                     else res = a / b;
                  end
                  3'd6: begin
                     if (b == 0)                            begin res = a;  lat = 2; end
                     else if (a == 32'h80000000 && b == '1) begin res = '0; lat = 2; end
                     else res = 32'(sa % sb);
                  end
                  default: begin
                     if (b == 0) begin res = a; lat = 2; end
                     else res = a % b;
                  end
               endcase
            end
         end
         4'd1: res = b;
         4'd2: begin
            if (f3 == 3'd5)      br = (sa >= sb);
            else if (f3 == 3'd1) br = (a != b);
         end
         4'd3: res = a + 32'd4;
         4'd5: begin
            if (f3 == 3'd1)      res = a << b[4:0];
            else if (f3 == 3'd5) res = 32'(sa >>> b[4:0]);
         end
         default: res = a + b;
      endcase
   endfunction

   // Issue one operation and check result, branch, latency and ready profile
   task automatic run_op(input string tag, input logic [3:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] e_res;
      logic        e_br;
      int          e_lat;
      int          lat;
      int          rdy_low;
      model(op, f3, f7, a, b, e_res, e_br, e_lat);
      @(negedge clk_i);
      check({tag, "/rdy_in"}, 64'(ready_o), 64'(1));
      alu_op_i  = op;
      funct_3_i = f3;
      funct_7_i = f7;
      op_a_i    = a;
      op_b_i    = b;
      valid_i   = 1'b1;
      @(posedge clk_i); #1;
      valid_i   = 1'b0;
      alu_op_i  = 4'($urandom);
      funct_3_i = 3'($urandom);
      funct_7_i = 7'($urandom);
      op_a_i    = $urandom;
      op_b_i    = $urandom;
      lat       = 1;
      rdy_low   = 0;
      while (!valid_o && lat < 200) begin
         if (!ready_o) rdy_low++;
         @(posedge clk_i); #1;
         lat++;
      end
      check({tag, "/lat"}, 64'(lat), 64'(e_lat));
      check({tag, "/res"}, 64'(result_o), 64'(e_res));
      check({tag, "/br"}, 64'(branch_o), 64'(e_br));
      check({tag, "/rdy_low"}, 64'(rdy_low), 64'(e_lat - 1));
      last_res = e_res;
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          pulses;
      logic [3:0]  r_op;
      logic [2:0]  r_f3;
      logic [6:0]  r_f7;

      rst_i     = 1'b1;
      flush_i   = 1'b0;
      valid_i   = 1'b0;
      alu_op_i  = '0;
      funct_3_i = '0;
      funct_7_i = '0;
      op_a_i    = '0;
      op_b_i    = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_res", 64'(result_o), 64'(0));
      check("rst_br", 64'(branch_o), 64'(0));
      check("rst_valid", 64'(valid_o), 64'(0));
      check("rst_ready", 64'(ready_o), 64'(1));
      @(negedge clk_i);
      rst_i = 1'b0;

      // Back-to-back ADD then SUB
      @(negedge clk_i);
      alu_op_i = 4'd0; funct_3_i = 3'd0; funct_7_i = 7'h00;
      op_a_i = 32'd5; op_b_i = 32'd7; valid_i = 1'b1;
      @(posedge clk_i); #1;
      check("b2b_add_v", 64'(valid_o), 64'(1));
      check("b2b_add_res", 64'(result_o), 64'(12));
      check("b2b_add_rdy", 64'(ready_o), 64'(1));
      funct_7_i = 7'h20;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check("b2b_sub_v", 64'(valid_o), 64'(1));
      check("b2b_sub_res", 64'(result_o), 64'hFFFFFFFE);
      check("b2b_sub_rdy", 64'(ready_o), 64'(1));
      @(posedge clk_i); #1;
      check("b2b_idle_v", 64'(valid_o), 64'(0));
      check("b2b_hold_res", 64'(result_o), 64'hFFFFFFFE);
      last_res = 32'hFFFFFFFE;

      // Directed single-cycle cases
      run_op("sra",     4'd5, 3'd5, 7'h00, 32'h80000000, 32'd4);
      run_op("sll",     4'd5, 3'd1, 7'h00, 32'h00000003, 32'h21);
      run_op("bge_neg", 4'd2, 3'd5, 7'h00, 32'hFFFFFFFF, 32'd1);
      run_op("bge_pos", 4'd2, 3'd5, 7'h00, 32'd1, 32'hFFFFFFFF);
      run_op("bne",     4'd2, 3'd1, 7'h00, 32'd3, 32'd4);
      run_op("beq_oth", 4'd2, 3'd0, 7'h00, 32'd3, 32'd4);
      run_op("lui",     4'd1, 3'd0, 7'h00, 32'h1234, 32'hABCD0000);
      run_op("jal",     4'd3, 3'd0, 7'h00, 32'h1000, 32'h55);
      run_op("xor",     4'd0, 3'd4, 7'h00, 32'hF0F0F0F0, 32'h0FF00FF0);

      // Multiply / divide cases (single-cycle ADD when the extension is off)
      run_op("mul",     4'd0, 3'd0, 7'h01, 32'd7, 32'hFFFFFFFD);
      run_op("mulhu",   4'd0, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op("mulh",    4'd0, 3'd1, 7'h01, 32'h80000000, 32'h80000000);
      run_op("mulhsu",  4'd0, 3'd2, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op("div",     4'd0, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2);
      run_op("rem",     4'd0, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2);
      run_op("divu_z",  4'd0, 3'd5, 7'h01, 32'd7, 32'd0);
      run_op("rem_z",   4'd0, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd0);
      run_op("div_ovf", 4'd0, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF);
      run_op("rem_ovf", 4'd0, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF);
      run_op("divu_mx", 4'd0, 3'd5, 7'h01, 32'h80000000, 32'hFFFFFFFF);
      run_op("md_add",  4'd0, 3'd0, 7'h01, 32'd3, 32'd4);

      // Flush while idle blocks the accept
      @(negedge clk_i);
      alu_op_i = 4'd0; funct_3_i = 3'd0; funct_7_i = 7'h00;
      op_a_i = 32'd9; op_b_i = 32'd9; valid_i = 1'b1; flush_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0; flush_i = 1'b0;
      check("iflush_v", 64'(valid_o), 64'(0));
      check("iflush_res", 64'(result_o), 64'(last_res));
      @(posedge clk_i); #1;
      check("iflush_v2", 64'(valid_o), 64'(0));

`ifdef ALU_EXEC_MD_EN
      // Flush on the 10th iteration cycle of a divide
      @(negedge clk_i);
      alu_op_i = 4'd0; funct_3_i = 3'd4; funct_7_i = 7'h01;
      op_a_i = 32'd100; op_b_i = 32'd7; valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check("dflush_busy", 64'(ready_o), 64'(0));
      repeat (9) @(posedge clk_i);
      #1;
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      check("dflush_rdy", 64'(ready_o), 64'(1));
      check("dflush_v", 64'(valid_o), 64'(0));
      check("dflush_res", 64'(result_o), 64'(last_res));
      pulses = 0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (valid_o) pulses++;
      end
      check("dflush_no_v", 64'(pulses), 64'(0));
`endif
      run_op("post_flush_add", 4'd0, 3'd0, 7'h00, 32'd1, 32'd1);

      // Randomized operations against the model
      for (int i = 0; i < 150; i++) begin
         r_op = 4'($urandom_range(0, 7));
         r_f3 = 3'($urandom);
         case ($urandom_range(0, 3))
            0:       r_f7 = 7'h00;
            1:       r_f7 = 7'h20;
            2:       r_f7 = 7'h01;
            default: r_f7 = 7'($urandom);
         endcase
         run_op($sformatf("rnd%0d", i), r_op, r_f3, r_f7, rnd_operand(), rnd_operand());
      end

      // Reset in the middle of a multiply
      @(negedge clk_i);
      alu_op_i = 4'd0; funct_3_i = 3'd0; funct_7_i = 7'h01;
      op_a_i = 32'd7; op_b_i = 32'hFFFFFFFD; valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check("mrst_res", 64'(result_o), 64'(0));
      check("mrst_br", 64'(branch_o), 64'(0));
      check("mrst_v", 64'(valid_o), 64'(0));
      check("mrst_rdy", 64'(ready_o), 64'(1));
      pulses = 0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (valid_o) pulses++;
      end
      check("mrst_no_v", 64'(pulses), 64'(0));
      run_op("post_rst_sub", 4'd0, 3'd0, 7'h20, 32'd10, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
